// File: rtl/sll_unit.sv
// Registered logical-left shifter. A barrel of SHAMT_W conditional 2^k stages
// feeds a single result register that loads only on in_valid.
module sll_stage #(
  parameter int WIDTH = 64,
  parameter int SH    = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  assign dout = en ? {din[WIDTH-1-SH:0], {SH{1'b0}}} : din;
endmodule

module sll_unit #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   Result
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   a;
  } sll_req_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] res;
  } sll_rsp_t;

  sll_req_t req;
  sll_rsp_t rsp;
  logic [SHAMT_W:0][WIDTH-1:0] stg;
  logic [STAGES:0]             vld_pipe;
  logic [WIDTH-1:0]            res_q;

  assign req.a     = A;
  assign req.shamt = shamt;
  assign stg[0]    = req.a;

  // stage k moves the word by 2^k when shamt[k] is set
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stg
    sll_stage #(.WIDTH(WIDTH), .SH(1 << k)) u_stg (
      .en   (req.shamt[k]),
      .din  (stg[k]),
      .dout (stg[k+1])
    );
  end

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      res_q              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      // result holds while idle so the mux input stays quiet
      if (in_valid) res_q <= stg[SHAMT_W];
    end
  end

  assign rsp.vld   = vld_pipe[STAGES];
  assign rsp.res   = res_q;
  assign out_valid = rsp.vld;
  assign Result    = rsp.res;
endmodule

// File: tb/tb_sll_unit.sv
// Randomized and directed checks of sll_unit against an arithmetic
// (multiply-by-power-of-two) reference with one-cycle alignment.
module tb_sll_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] A;
  logic [5:0]  shamt;
  logic        out_valid;
  logic [63:0] Result;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] exp_res;
  logic        exp_vld;

  sll_unit #(.WIDTH(64), .SHAMT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .shamt     (shamt),
    .out_valid (out_valid),
    .Result    (Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // a * 2^s, truncated to 64 bits
  function automatic logic [63:0] model_sll(input logic [63:0] a, input int s);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < s; i++) m = m * 64'd2;
    return a * m;
  endfunction

  // inputs applied at negedge, outputs checked at the following negedge
  task automatic step(input string tag, input logic v, input logic [63:0] a, input logic [5:0] s);
    in_valid = v;
    A        = a;
    shamt    = s;
    @(posedge clk);
    if (v) exp_res = model_sll(a, int'(s));
    exp_vld = v;
    @(negedge clk);
    chk({tag, ".vld"}, 64'(out_valid), 64'(exp_vld));
    chk({tag, ".res"}, Result, exp_res);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; shamt = '0;
    exp_res = '0; exp_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.vld", 64'(out_valid), 64'd0);
    chk("rst.res", Result, 64'd0);
    rst = 1'b0;

    // directed values
    step("t1",    1'b1, 64'h00000000000000FF, 6'd0);
    step("t2a",   1'b1, 64'h00000000000000FF, 6'd1);
    step("t2b",   1'b1, 64'h00000000000000FF, 6'd8);
    step("t3a",   1'b1, 64'h00000000FFFFFFFF, 6'd32);
    step("t3b",   1'b1, 64'h8000000000000000, 6'd63);
    step("t3c",   1'b1, 64'h0000000000000001, 6'd63);
    chk("t3c.lit", Result, 64'h8000000000000000);

    // back-to-back then idle with garbage on inputs: result must hold
    step("b2b0",  1'b1, 64'h0123456789ABCDEF, 6'd4);
    step("b2b1",  1'b1, 64'hFEDCBA9876543210, 6'd12);
    step("b2b2",  1'b1, 64'hDEADBEEFCAFEF00D, 6'd33);
    step("idle0", 1'b0, 64'hFFFFFFFFFFFFFFFF, 6'd5);
    step("idle1", 1'b0, 64'h5555AAAA5555AAAA, 6'd17);

    // reset between capture and its output edge, no clock edge needed
    step("pre",   1'b1, 64'h00000000000000FF, 6'd8);
    in_valid = 1'b1; A = 64'hFFFFFFFFFFFFFFFF; shamt = 6'd3;
    #2 rst = 1'b1;
    #1;
    chk("arst.vld", 64'(out_valid), 64'd0);
    chk("arst.res", Result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_res = '0; exp_vld = 1'b0;
    step("post0", 1'b0, 64'h1234, 6'd1);
    step("post1", 1'b0, 64'h5678, 6'd2);
    step("post2", 1'b1, 64'h0000000000000003, 6'd62);

    // random sweep across every shift amount with random idle gaps
    for (int i = 0; i < 10000; i++) begin
      logic [63:0] ra;
      logic        rv;
      ra = {32'($urandom), 32'($urandom)};
      rv = ($urandom_range(0, 7) != 0);
      step("rnd", rv, ra, 6'(i % 64));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
